// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage iterative multiply/divide unit.
package ex_muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] FN_MULT  = 2'b00;
  localparam logic [1:0] FN_MULTU = 2'b01;
  localparam logic [1:0] FN_DIV   = 2'b10;
  localparam logic [1:0] FN_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Per-operation control captured at accept time.
  typedef struct packed {
    logic div;
    logic neg_res;
    logic neg_rem;
  } op_ctl_t;

endpackage

// File: rtl/ex_muldiv_step.sv
// One combinational radix-2 iteration: shift-add multiply or restoring divide.
// Mul accumulator is {P_hi,P_lo}; div accumulator is {R,Q}.
module ex_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              mode_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rsh;
  logic [XLEN-1:0] rdiff;

  always_comb begin
    sum   = '0;
    rsh   = '0;
    rdiff = '0;
    acc_o = acc_i;
    if (!mode_i) begin
      // The add carry lands in bit 2*XLEN-1 after the right shift.
      sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
      acc_o = {sum, acc_i[XLEN-1:1]};
    end else begin
      // R stays below the divisor, so the difference always fits in XLEN bits.
      rsh   = acc_i[2*XLEN-1:XLEN-1];
      rdiff = rsh[XLEN-1:0] - opnd_i;
      if (rsh >= {1'b0, opnd_i}) begin
        acc_o = {rdiff, acc_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = {rsh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO: XLEN iterations, result one edge after the last.
// Stall holds the pipeline from the accept cycle through RUN; drops in the DONE cycle.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic            Start,
  input  logic [1:0]      Fn,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [XLEN-1:0] Hi,
  output logic [XLEN-1:0] Lo,
  output logic            Busy,
  output logic            Done,
  output logic            Stall
);

  localparam int CW = $clog2(XLEN);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  op_ctl_t           ctl_q, ctl_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  logic              is_signed, is_div, b_zero;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] step_acc, prod;
  logic [XLEN-1:0]   quo, rem;

  ex_muldiv_step #(.XLEN(XLEN)) u_step (
    .mode_i (ctl_q.div),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  always_comb begin
    is_signed = ~Fn[0];
    is_div    = Fn[1];
    b_zero    = (B == '0);
    a_mag     = (is_signed && A[XLEN-1]) ? -A : A;
    b_mag     = (is_signed && B[XLEN-1]) ? -B : B;

    prod = ctl_q.neg_res ? -step_acc : step_acc;
    quo  = ctl_q.neg_res ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    rem  = ctl_q.neg_rem ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];

    state_d = state_q;
    cnt_d   = cnt_q;
    ctl_d   = ctl_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d       = S_RUN;
          cnt_d         = '0;
          ctl_d.div     = is_div;
          // Divide-by-zero keeps the all-ones quotient; the remainder path
          // naturally ends holding the dividend magnitude.
          ctl_d.neg_res = is_signed && (A[XLEN-1] ^ B[XLEN-1]) && !(is_div && b_zero);
          ctl_d.neg_rem = is_signed && is_div && A[XLEN-1];
          opnd_d        = is_div ? b_mag : a_mag;
          acc_d         = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
        end
      end
      S_RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (ctl_q.div) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            hi_d = prod[2*XLEN-1:XLEN];
            lo_d = prod[XLEN-1:0];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctl_q   <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Hi    = hi_q;
  assign Lo    = lo_q;
  assign Busy  = (state_q == S_RUN);
  assign Done  = (state_q == S_DONE);
  assign Stall = ((state_q == S_IDLE) && Start) || (state_q == S_RUN);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed plus random bench for ex_muldiv against a plain-arithmetic HI/LO model.
module tb_ex_muldiv;

  logic        Clk;
  logic        Clr;
  logic        Start;
  logic [1:0]  Fn;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        Done;
  logic        Stall;

  int total;
  int bad;

  ex_muldiv #(.XLEN(32)) dut (
    .Clk   (Clk),
    .Clr   (Clr),
    .Start (Start),
    .Fn    (Fn),
    .A     (A),
    .B     (B),
    .Hi    (Hi),
    .Lo    (Lo),
    .Busy  (Busy),
    .Done  (Done),
    .Stall (Stall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Returns {HI, LO} as the architecture defines them.
  function automatic logic [63:0] model(input logic [1:0] fn, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    q   = 0;
    r   = 0;
    res = '0;
    case (fn)
      2'b00: res = 64'(sa * sb);
      2'b01: res = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          if (fn == 2'b10) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'({32'b0, a}) / longint'({32'b0, b});
            r = longint'({32'b0, a}) % longint'({32'b0, b});
          end
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered just after a falling edge; leaves just after the falling edge that
  // follows DONE with Start still high, so the caller decides what comes next.
  task automatic run_op(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, input string tag);
    logic [63:0] exp;
    int st;
    int bz;
    int n;
    exp   = model(fn, a, b);
    Fn    = fn;
    A     = a;
    B     = b;
    Start = 1'b1;
    st    = 0;
    bz    = 0;
    n     = 0;
    #1;
    while (!Done && n < 60) begin
      if (Stall) st++;
      if (Busy) bz++;
      if (scramble && Busy) begin
        A  = $urandom;
        B  = $urandom;
        Fn = 2'($urandom_range(0, 3));
      end
      @(negedge Clk);
      #1;
      n++;
    end
    chk({tag, "_done_seen"}, 64'(Done), 64'd1);
    chk({tag, "_stall_cycles"}, 64'(st), 64'd33);
    chk({tag, "_busy_cycles"}, 64'(bz), 64'd32);
    chk({tag, "_stall_in_done"}, 64'(Stall), 64'd0);
    chk({tag, "_hi"}, 64'(Hi), 64'(exp[63:32]));
    chk({tag, "_lo"}, 64'(Lo), 64'(exp[31:0]));
    @(negedge Clk);
    #1;
    chk({tag, "_done_one_cycle"}, 64'(Done), 64'd0);
    chk({tag, "_no_restart"}, 64'(Busy), 64'd0);
    chk({tag, "_hilo_held"}, {Hi, Lo}, exp);
  endtask

  initial begin
    int dcnt;
    logic [1:0]  rfn;
    logic [31:0] ra, rb;
    total = 0;
    bad   = 0;
    Clr   = 1'b1;
    Start = 1'b0;
    Fn    = 2'b00;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge Clk);
    #1;
    chk("reset_hilo", {Hi, Lo}, 64'd0);
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_done", 64'(Done), 64'd0);
    chk("reset_stall", 64'(Stall), 64'd0);
    Clr = 1'b0;
    @(negedge Clk);
    #1;
    chk("idle_no_start_stall", 64'(Stall), 64'd0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    chk("multu_max_hi_const", 64'(Hi), 64'hFFFF_FFFE);
    chk("multu_max_lo_const", 64'(Lo), 64'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg3x7");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minsq");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7by2");
    run_op(2'b11, 32'd100, 32'd7, 1'b0, "divu_100by7");
    run_op(2'b11, 32'h1234_5678, 32'd0, 1'b0, "divu_by0");
    run_op(2'b10, 32'h8000_0005, 32'd0, 1'b0, "div_neg_by0");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    // Immediate follow-on with operands churned during RUN.
    run_op(2'b11, 32'd9, 32'd4, 1'b1, "divu_9by4_b2b");

    Start = 1'b0;
    @(negedge Clk);
    #1;
    Fn    = 2'b01;
    A     = 32'd3;
    B     = 32'd5;
    Start = 1'b1;
    repeat (10) begin
      @(negedge Clk);
      #1;
    end
    chk("clr_pre_busy", 64'(Busy), 64'd1);
    Clr   = 1'b1;
    Start = 1'b0;
    @(negedge Clk);
    #1;
    chk("clr_busy", 64'(Busy), 64'd0);
    chk("clr_stall", 64'(Stall), 64'd0);
    chk("clr_hilo", {Hi, Lo}, 64'd0);
    chk("clr_done", 64'(Done), 64'd0);
    Clr  = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge Clk);
      #1;
      if (Done) dcnt++;
    end
    chk("clr_no_done_pulse", 64'(dcnt), 64'd0);
    run_op(2'b01, 32'd3, 32'd5, 1'b0, "multu_after_clr");
    chk("multu_after_clr_lo15", 64'(Lo), 64'd15);

    for (int i = 0; i < 30; i++) begin
      rfn = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 16));
      if ($urandom_range(0, 2) == 0) begin
        Start = 1'b0;
        @(negedge Clk);
        #1;
      end
      run_op(rfn, ra, rb, 1'(i % 2), $sformatf("rand%0d", i));
    end

    Start = 1'b0;
    repeat (3) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
